event_capture_fifo: RTL and testbench

Upstream stage of the convolution engine. It accepts spike events (x,y) from the input source (sensor bridge or previous layer) and discards coordinates outside the image. Valid events are buffered in a FIFO and presented one at a time on the event handshake the convolution consumes: valid/coord out, ready/ack in. It decouples bursty event arrival from the multi-cycle kernel update.

---
 rtl/event_capture_fifo_pkg.sv | 23 ++
 rtl/event_capture_fifo_if.sv | 18 +
 rtl/event_capture_fifo_sync_fifo.sv | 63 ++++++
 rtl/event_capture_fifo.sv | 116 +++++++++++
 tb/tb_event_capture_fifo.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/event_capture_fifo_pkg.sv
// Shared types and defaults for the event capture front end.
//   vec2_t           : packed {x,y} event coordinate
//   coord_in_bounds  : 1 when x<w and y<h
package event_capture_fifo_pkg;
  localparam int VEC_COORD_BITS           = 8;
  localparam int DEFAULT_EVENT_FIFO_DEPTH = 16;
  localparam int DEFAULT_STAT_BITS        = 16;

  typedef struct packed {
    logic [VEC_COORD_BITS-1:0] x;
    logic [VEC_COORD_BITS-1:0] y;
  } vec2_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_RELEASE = 2'd2
  } out_state_e;

  function automatic logic coord_in_bounds(vec2_t c, int unsigned w, int unsigned h);
    return (32'(c.x) < w) && (32'(c.y) < h);
  endfunction
endpackage

// File: rtl/event_capture_fifo_if.sv
// Event handshakes around the capture FIFO.
//   in_*    : source -> FIFO (valid/coord, ready back)
//   event_* : FIFO -> convolution (valid/coord, ready/ack back)
// master = environment (source + consumer), slave = the FIFO block.
interface event_capture_fifo_if #(parameter int CW = 16) ();
  logic          in_valid;
  logic [CW-1:0] in_coord;
  logic          in_ready;
  logic          event_valid;
  logic [CW-1:0] event_coord;
  logic          event_ready;
  logic          event_ack;

  modport master (output in_valid, in_coord, event_ready, event_ack,
                  input  in_ready, event_valid, event_coord);
  modport slave  (input  in_valid, in_coord, event_ready, event_ack,
                  output in_ready, event_valid, event_coord);
endinterface

// File: rtl/event_capture_fifo_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and occupancy count.
//   push_i/pop_i are ignored when full/empty respectively.
//   rdata_o is the current head (mem[rd_ptr]), valid when !empty_o.
module event_capture_fifo_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CNTW'(1);
    if (!do_push && do_pop) count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage has no reset; count qualifies its contents.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop_i && empty_o)) else $error("sync_fifo: pop while empty");
      assert (count_q <= CNTW'(DEPTH)) else $error("sync_fifo: count overflow");
    end
  end
endmodule

// File: rtl/event_capture_fifo.sv
// Event capture FIFO: filters out-of-image spike events, buffers valid
// ones and offers them one at a time to the convolution stage.
//   clk, reset, clear : clock, sync active-high reset, sync flush
//   bus               : in_* source handshake, event_* consumer handshake
//   fifo_count/full/empty : occupancy status
//   oob_count, drop_count : saturating discard statistics
module event_capture_fifo
  import event_capture_fifo_pkg::*;
#(
  parameter int COORD_BITS   = VEC_COORD_BITS,
  parameter int IMG_WIDTH    = 32,
  parameter int IMG_HEIGHT   = 32,
  parameter int FIFO_DEPTH   = DEFAULT_EVENT_FIFO_DEPTH,
  parameter bit DROP_ON_FULL = 1'b0,
  parameter int STAT_BITS    = DEFAULT_STAT_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  event_capture_fifo_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [STAT_BITS-1:0]        oob_count,
  output logic [STAT_BITS-1:0]        drop_count
);
  vec2_t          in_c, head_c, ev_coord_q;
  logic           in_bounds, accept, oob_evt, drop_evt, push, pop;
  logic           ev_valid_q, ack_q;
  out_state_e     state_q;
  logic [STAT_BITS-1:0] oob_q, drop_q;
  logic           unused_ready;

  // Consumer readiness is informational only; popping is driven by ack.
  assign unused_ready = bus.event_ready;

  assign in_c      = vec2_t'(bus.in_coord[2*COORD_BITS-1:0]);
  assign in_bounds = coord_in_bounds(in_c, IMG_WIDTH, IMG_HEIGHT);

  // Full comes from the registered count, so a same-cycle pop never frees a slot.
  assign bus.in_ready = DROP_ON_FULL ? !reset : (!fifo_full && !reset);
  assign accept   = bus.in_valid && bus.in_ready;
  assign oob_evt  = accept && !in_bounds;
  assign drop_evt = accept && in_bounds && fifo_full;
  assign push     = accept && in_bounds && !fifo_full && !clear;
  assign pop      = (state_q == ST_OFFER) && bus.event_ack && !ack_q;

  event_capture_fifo_sync_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(vec2_t))) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_c),
    .rdata_o (head_c),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      oob_q  <= '0;
      drop_q <= '0;
    end else begin
      if (oob_evt && (oob_q != '1))   oob_q  <= oob_q + STAT_BITS'(1);
      if (drop_evt && (drop_q != '1)) drop_q <= drop_q + STAT_BITS'(1);
    end
  end

  assign oob_count  = oob_q;
  assign drop_count = drop_q;

  // Output FSM. ack_q gives the rising-edge detect so a long ack pops once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= ST_IDLE;
      ev_valid_q <= 1'b0;
      ev_coord_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= bus.event_ack;
      case (state_q)
        ST_IDLE: if (!fifo_empty) begin
          state_q    <= ST_OFFER;
          ev_valid_q <= 1'b1;
          ev_coord_q <= head_c;
        end
        ST_OFFER: if (pop) begin
          state_q    <= ST_RELEASE;
          ev_valid_q <= 1'b0;
        end
        ST_RELEASE: if (!bus.event_ack) begin
          if (!fifo_empty) begin
            state_q    <= ST_OFFER;
            ev_valid_q <= 1'b1;
            ev_coord_q <= head_c;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ev_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.event_valid = ev_valid_q;
  assign bus.event_coord = ev_coord_q;

  a_coord_stable: assert property (@(posedge clk) disable iff (reset || clear)
    (state_q == ST_OFFER && !pop) |=> $stable(ev_coord_q) && ev_valid_q)
    else $error("event_coord changed while offered");
endmodule

// File: tb/tb_event_capture_fifo.sv
module tb_event_capture_fifo;
  logic clk = 1'b0, reset, clear;
  always #5 clk = ~clk;

  event_capture_fifo_if #(.CW(16)) a ();
  event_capture_fifo_if #(.CW(16)) b ();

  logic [5:0]  cnt_a, cnt_b;
  logic        full_a, full_b, empty_a, empty_b;
  logic [15:0] oob_a, oob_b, drop_a, drop_b;

  event_capture_fifo #(.DROP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .bus(a),
    .fifo_count(cnt_a[4:0]), .fifo_full(full_a), .fifo_empty(empty_a),
    .oob_count(oob_a), .drop_count(drop_a));
  event_capture_fifo #(.DROP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .bus(b),
    .fifo_count(cnt_b[4:0]), .fifo_full(full_b), .fifo_empty(empty_b),
    .oob_count(oob_b), .drop_count(drop_b));
  assign cnt_a[5] = 1'b0;
  assign cnt_b[5] = 1'b0;

  int checks = 0, errors = 0;
  int idx = 0;
  bit prod_en = 0;

  function automatic logic [15:0] mk(int x, int y);
    return {x[7:0], y[7:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; also advances the streaming producer on bus a when enabled.
  task automatic step();
    logic fire;
    fire = prod_en && a.in_valid && a.in_ready;
    @(posedge clk); #1;
    if (fire) begin
      idx++;
      if (idx < 20) a.in_coord = mk(idx, 0);
      else a.in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid_a();
    int n = 0;
    while (!a.event_valid && n < 20) begin step(); n++; end
    if (!a.event_valid) chk("timeout_event_valid", 0, 1);
  endtask

  initial begin
    reset = 1; clear = 0;
    a.in_valid = 0; a.in_coord = 0; a.event_ready = 1; a.event_ack = 0;
    b.in_valid = 0; b.in_coord = 0; b.event_ready = 1; b.event_ack = 0;
    step(); step();
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_in_ready_b", b.in_ready, 0);
    chk("rst_valid", a.event_valid, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_empty", empty_a, 1);
    reset = 0; #1;
    chk("in_ready_after_rst", a.in_ready, 1);

    // single event, ack two cycles after offer
    a.in_valid = 1; a.in_coord = mk(3, 4);
    step(); a.in_valid = 0;
    chk("single_count1", cnt_a, 1);
    chk("single_valid_lat0", a.event_valid, 0);
    step();
    chk("single_valid", a.event_valid, 1);
    chk("single_coord", a.event_coord, 16'h0304);
    step();
    a.event_ack = 1; step(); a.event_ack = 0;
    chk("single_count0", cnt_a, 0);
    chk("single_valid_drop", a.event_valid, 0);
    step(); step();
    chk("single_idle_valid", a.event_valid, 0);
    chk("single_empty", empty_a, 1);

    // out-of-bounds events
    a.in_valid = 1; a.in_coord = mk(32, 0); step();
    a.in_coord = mk(0, 40); step();
    a.in_valid = 0; step();
    chk("oob_count", oob_a, 2);
    chk("oob_empty", empty_a, 1);
    chk("oob_valid", a.event_valid, 0);

    // backpressure: 20 offered, 16 accepted, then drain in order
    idx = 0; prod_en = 1; a.in_valid = 1; a.in_coord = mk(0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("bp_accepted", idx, 16);
    chk("bp_full", full_a, 1);
    chk("bp_count", cnt_a, 16);
    chk("bp_in_ready", a.in_ready, 0);
    for (int k = 0; k < 20; k++) begin
      wait_valid_a();
      chk($sformatf("bp_order_%0d", k), a.event_coord, mk(k, 0));
      a.event_ack = 1; step(); a.event_ack = 0; step();
    end
    prod_en = 0;
    chk("bp_all_pushed", idx, 20);
    chk("bp_drained", cnt_a, 0);
    chk("bp_drop_a", drop_a, 0);

    // long ack pops exactly once
    a.in_valid = 1; a.in_coord = mk(5, 5); step();
    a.in_coord = mk(6, 6); step(); a.in_valid = 0;
    chk("hold_first", a.event_coord, 16'h0505);
    a.event_ack = 1;
    for (int i = 0; i < 5; i++) step();
    chk("hold_one_pop", cnt_a, 1);
    chk("hold_valid_low", a.event_valid, 0);
    a.event_ack = 0; step();
    chk("hold_next_valid", a.event_valid, 1);
    chk("hold_next_coord", a.event_coord, 16'h0606);
    a.event_ack = 1; step(); a.event_ack = 0; step();
    chk("hold_drained", cnt_a, 0);

    // reset mid-offer with three buffered
    a.in_valid = 1;
    for (int i = 1; i <= 3; i++) begin a.in_coord = mk(i, i); step(); end
    a.in_valid = 0;
    chk("mid_count3", cnt_a, 3);
    chk("mid_offer", a.event_valid, 1);
    reset = 1; #1;
    chk("mid_rst_in_ready", a.in_ready, 0);
    step();
    chk("mid_rst_valid", a.event_valid, 0);
    chk("mid_rst_count", cnt_a, 0);
    chk("mid_rst_oob", oob_a, 0);
    reset = 0; #1;

    // drop-on-full instance
    b.in_valid = 1;
    begin
      int ready_lows = 0;
      for (int i = 0; i < 20; i++) begin
        b.in_coord = mk(i, 1);
        if (!b.in_ready) ready_lows++;
        step();
      end
      chk("dof_ready_lows", ready_lows, 0);
    end
    b.in_valid = 0;
    chk("dof_count", cnt_b, 16);
    chk("dof_drop", drop_b, 4);
    chk("dof_full", full_b, 1);
    chk("dof_in_ready", b.in_ready, 1);
    chk("dof_head", b.event_coord, 16'h0001);

    // clear flushes state, stats and a same-cycle push
    a.in_valid = 1; a.in_coord = mk(40, 1); step();
    for (int i = 1; i <= 3; i++) begin a.in_coord = mk(i, i); step(); end
    chk("clr_pre_oob", oob_a, 1);
    chk("clr_pre_count", cnt_a, 3);
    clear = 1; a.in_coord = mk(9, 9); step();
    clear = 0; a.in_valid = 0;
    chk("clr_count", cnt_a, 0);
    chk("clr_valid", a.event_valid, 0);
    chk("clr_oob", oob_a, 0);
    chk("clr_drop_b", drop_b, 0);
    chk("clr_count_b", cnt_b, 0);
    step();
    chk("clr_push_discarded", empty_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
